mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous word RAM (1-cycle read latency) between the instruction-fetch requester (I, read-only) and the memory-access requester (D, load/store with byte strobes).
- Sits between the fetch and memory-access stages of the RV32 core and a unified instruction/data RAM.
- D has priority, with an anti-starvation streak limit for I.
- Generates same-cycle grants and next-cycle response strobes, and routes each response to the port that issued the request.

Parameters:
- ADDR_W, 10, word-address width of RAM (RAM depth = 2**ADDR_W words).
- BASE_ADDR, 32'h0000_0000, byte base address of RAM window (aligned to 4*2**ADDR_W).
- STREAK_MAX, 4, max consecutive D grants while I is waiting before I is forced through (range 1..15).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- i_req  in  1  fetch request.
- i_addr  in  32  fetch byte address; bits [1:0] ignored.
- i_gnt  out  1  fetch request accepted this cycle (combinational).
- i_rvalid  out  1  fetch response valid (cycle after grant).
- i_rdata  out  32  fetch data; 0 when i_rvalid=0.
- i_err  out  1  with i_rvalid: fetch address outside window.
- d_req  in  1  data request.
- d_we  in  1  1=store, 0=load.
- d_be  in  4  store byte enables, lane n = bits [8n+7:8n].
- d_addr  in  32  data byte address; bits [1:0] ignored.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  data response valid (cycle after grant; loads and stores).
- d_rdata  out  32  load data; 0 for stores, errors, or when d_rvalid=0.
- d_err  out  1  with d_rvalid: data address outside window.
- ram_en  out  1  RAM access enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_we=0.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous, active-high.
- Reset values: streak counter=0. Pending flags (pend_i, pend_d, pend_err, pend_we) = 0. All outputs are 0 during and after reset until a new request is granted.
- Arbitration (combinational, every cycle):
  - Only d_req: d_gnt=1.
  - Only i_req: i_gnt=1.
  - Both requesting: i_gnt=1 if streak==STREAK_MAX, otherwise d_gnt=1.
  - Never both grants in one cycle. No grant while rst=1.
- Streak counter (registered):
  - Increments on each cycle with d_gnt=1 and i_req=1. Saturates at STREAK_MAX.
  - Clears to 0 on i_gnt=1 or i_req=0.
- In-window check: addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
- RAM drive, granted port, in window:
  - ram_en=1, ram_addr=addr[ADDR_W+1:2].
  - ram_we = d_we ? d_be : 4'b0 (I is always 0).
  - ram_wdata=d_wdata.
- RAM drive, out of window or no grant: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Registered response pipeline (latency exactly 1 cycle):
  - pend_i<=i_gnt. pend_d<=d_gnt.
  - pend_err<=grant & ~in-window. pend_we<=d_gnt & d_we.
  - i_rvalid=pend_i. d_rvalid=pend_d.
  - i_err = pend_i & pend_err. d_err = pend_d & pend_err.
  - i_rdata = (pend_i & ~pend_err) ? ram_rdata : 0.
  - d_rdata = (pend_d & ~pend_we & ~pend_err) ? ram_rdata : 0.
- Throughput: one grant per cycle, back-to-back requests allowed. Requesters hold req/addr/data stable until their gnt.
- Store with d_be=4'b0000: granted, ram_en=1, ram_we=0, acknowledged normally. RAM contents unchanged.
- Out-of-window access: granted, no RAM access, response with err=1 and data 0. No RAM write occurs.
- Reset mid-operation: a request granted in the cycle before rst rises produces no response (pending flags cleared). The counter returns to 0.

Test Plan:
- Single fetch: i_req=1, i_addr=0x8, RAM word[2]=0x00500093 → i_gnt same cycle, ram_addr=2, ram_we=0. Next cycle i_rvalid=1, i_rdata=0x00500093, i_err=0.
- Byte store then load: store d_addr=0x104, d_be=4'b0010, d_wdata=0x0000AB00 over initial word 0x11223344 → ram_we=4'b0010, d_rvalid next cycle with d_rdata=0. Load 0x104 → d_rdata=0x1122AB44.
- Contention and starvation, STREAK_MAX=4: i_req and d_req held high for 10 cycles → grant sequence D,D,D,D,I,D,D,D,D,I. Each response appears on the correct port one cycle after its grant.
- Out of window, ADDR_W=10: d_addr=0x00001000 load → ram_en=0. Next cycle d_rvalid=1, d_err=1, d_rdata=0. Same test on the I port gives i_err=1.
- Reset mid-operation: grant D load at cycle N, rst=1 at cycle N+1 → d_rvalid=0 at N+1, all outputs 0, streak=0. Release rst, then a fetch of 0x0 works normally.
- Idle and back-to-back: 3 consecutive I fetches at 0x0, 0x4, 0x8 → i_rvalid high 3 consecutive cycles with words 0..2 in order. No req → ram_en=0, all rvalid=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Fetch, data and RAM-side signal bundle for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 10
) ();
  // Fetch port
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              i_err;
  // Data port
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  // RAM port
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  // Requester / RAM side
  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port word RAM between instruction fetch and
//               data access; data wins, fetch is forced through after a streak.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          STREAK_MAX = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mem_arbiter_if.slave  bus
);

  localparam int          c_tag_w      = 32 - ADDR_W - 2;
  localparam logic [c_tag_w-1:0] c_base_tag = BASE_ADDR[31:ADDR_W+2];
  localparam logic [3:0]  c_streak_max = 4'(STREAK_MAX);

  logic [3:0]        r_streak;
  logic              r_pend_i;
  logic              r_pend_d;
  logic              r_pend_err;
  logic              r_pend_we;

  logic              w_i_win;
  logic              w_d_win;
  logic              w_streak_full;
  logic              w_i_gnt;
  logic              w_d_gnt;
  logic              w_grant_err;
  logic              w_ram_en;
  logic [3:0]        w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [31:0]       w_ram_wdata;
  logic              w_unused;

  // Arbitration and RAM drive
  always_comb begin
    w_i_win       = (bus.i_addr[31:ADDR_W+2] == c_base_tag);
    w_d_win       = (bus.d_addr[31:ADDR_W+2] == c_base_tag);
    w_streak_full = (r_streak == c_streak_max);

    w_d_gnt = ~rst & bus.d_req & ~(bus.i_req & w_streak_full);
    w_i_gnt = ~rst & bus.i_req & (~bus.d_req | w_streak_full);

    w_grant_err = (w_i_gnt & ~w_i_win) | (w_d_gnt & ~w_d_win);

    w_ram_en    = 1'b0;
    w_ram_we    = 4'b0000;
    w_ram_addr  = '0;
    w_ram_wdata = 32'h0;
    if (w_d_gnt && w_d_win) begin
      w_ram_en    = 1'b1;
      w_ram_we    = bus.d_we ? bus.d_be : 4'b0000;
      w_ram_addr  = bus.d_addr[ADDR_W+1:2];
      w_ram_wdata = bus.d_wdata;
    end else if (w_i_gnt && w_i_win) begin
      w_ram_en    = 1'b1;
      w_ram_addr  = bus.i_addr[ADDR_W+1:2];
      w_ram_wdata = bus.d_wdata;
    end
  end

  // Streak of data grants seen while fetch is waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= 4'd0;
    end else if (w_i_gnt || !bus.i_req) begin
      r_streak <= 4'd0;
    end else if (w_d_gnt && !w_streak_full) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_i   <= 1'b0;
      r_pend_d   <= 1'b0;
      r_pend_err <= 1'b0;
      r_pend_we  <= 1'b0;
    end else begin
      r_pend_i   <= w_i_gnt;
      r_pend_d   <= w_d_gnt;
      r_pend_err <= w_grant_err;
      r_pend_we  <= w_d_gnt & bus.d_we;
    end
  end

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.ram_en    = w_ram_en;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_wdata = w_ram_wdata;

  // Responses are masked while rst is high so nothing leaks out during reset
  assign bus.i_rvalid = r_pend_i & ~rst;
  assign bus.d_rvalid = r_pend_d & ~rst;
  assign bus.i_err    = r_pend_i & r_pend_err & ~rst;
  assign bus.d_err    = r_pend_d & r_pend_err & ~rst;
  assign bus.i_rdata  = (r_pend_i & ~r_pend_err & ~rst) ? bus.ram_rdata : 32'h0;
  assign bus.d_rdata  = (r_pend_d & ~r_pend_we & ~r_pend_err & ~rst) ? bus.ram_rdata : 32'h0;

  assign w_unused = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  integer errors = 0;
  integer checks = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(10)) bus ();

  mem_arbiter #(
    .ADDR_W     (10),
    .BASE_ADDR  (32'h0000_0000),
    .STREAK_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous RAM model, 1-cycle read latency; contents reloaded on reset
  logic [31:0] mem [0:1023];
  logic [31:0] r_ram_q;
  assign bus.ram_rdata = r_ram_q;

  always @(posedge clk) begin
    if (rst) begin
      mem[0]    <= 32'hCAFE_0000;
      mem[1]    <= 32'hCAFE_0001;
      mem[2]    <= 32'h0050_0093;
      mem[10'h41] <= 32'h1122_3344;
      r_ram_q   <= 32'h0;
    end else if (bus.ram_en) begin
      if (bus.ram_we == 4'b0000) begin
        r_ram_q <= mem[bus.ram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic drive_idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = 4'b0000;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b want 00", {bus.i_gnt, bus.d_gnt});
    end
    checks++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== 47'h0) begin
      errors++; $display("FAIL reset_ram: en=%b we=%b addr=%h wdata=%h want 0",
                         bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    checks++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata} !== 68'h0) begin
      errors++; $display("FAIL reset_rsp: rv=%b%b err=%b%b idata=%h ddata=%h want 0",
                         bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    #1;
    checks++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.ram_en} !== 3'b000) begin
      errors++; $display("FAIL post_reset_idle: got %b want 000", {bus.i_rvalid, bus.d_rvalid, bus.ram_en});
    end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0008;
    #1;
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.ram_en, bus.ram_we} !== 7'b1010000) begin
      errors++; $display("FAIL fetch_grant: got gnt=%b%b en=%b we=%b want 10 1 0000",
                         bus.i_gnt, bus.d_gnt, bus.ram_en, bus.ram_we);
    end
    checks++;
    if (bus.ram_addr !== 10'd2) begin
      errors++; $display("FAIL fetch_ram_addr: got %0d want 2", bus.ram_addr);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({bus.i_rvalid, bus.i_err, bus.d_rvalid} !== 3'b100) begin
      errors++; $display("FAIL fetch_rsp: got rv/err/drv=%b want 100", {bus.i_rvalid, bus.i_err, bus.d_rvalid});
    end
    checks++;
    if (bus.i_rdata !== 32'h0050_0093) begin
      errors++; $display("FAIL fetch_data: got %h want 00500093", bus.i_rdata);
    end
  endtask

  task automatic test_byte_store_load();
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_be    = 4'b0010;
    bus.d_addr  = 32'h0000_0104;
    bus.d_wdata = 32'h0000_AB00;
    #1;
    checks++;
    if ({bus.d_gnt, bus.ram_en, bus.ram_we} !== 6'b110010) begin
      errors++; $display("FAIL store_drive: got gnt=%b en=%b we=%b want 1 1 0010", bus.d_gnt, bus.ram_en, bus.ram_we);
    end
    checks++;
    if ({bus.ram_addr, bus.ram_wdata} !== {10'h041, 32'h0000_AB00}) begin
      errors++; $display("FAIL store_bus: got addr=%h wdata=%h want 041 0000ab00", bus.ram_addr, bus.ram_wdata);
    end
    // zero-strobe store to the same word: enabled but writes nothing
    @(negedge clk);
    bus.d_be    = 4'b0000;
    bus.d_wdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL store_ack: got rv=%b err=%b data=%h want 1 0 0", bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
    checks++;
    if ({bus.d_gnt, bus.ram_en, bus.ram_we} !== 6'b110000) begin
      errors++; $display("FAIL zero_be_drive: got gnt=%b en=%b we=%b want 1 1 0000", bus.d_gnt, bus.ram_en, bus.ram_we);
    end
    @(negedge clk);
    bus.d_we = 1'b0;
    #1;
    checks++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL zero_be_ack: got rv=%b err=%b data=%h want 1 0 0", bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h1122_AB44}) begin
      errors++; $display("FAIL load_after_store: got rv=%b data=%h want 1 1122ab44", bus.d_rvalid, bus.d_rdata);
    end
  endtask

  task automatic test_out_of_window();
    @(negedge clk);
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_1000;
    #1;
    checks++;
    if ({bus.d_gnt, bus.ram_en, bus.ram_addr} !== {2'b10, 10'h0}) begin
      errors++; $display("FAIL oow_d_drive: got gnt=%b en=%b addr=%h want 1 0 0", bus.d_gnt, bus.ram_en, bus.ram_addr);
    end
    @(negedge clk);
    drive_idle();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_1000;
    #1;
    checks++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL oow_d_rsp: got rv=%b err=%b data=%h want 1 1 0", bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
    checks++;
    if ({bus.i_gnt, bus.ram_en} !== 2'b10) begin
      errors++; $display("FAIL oow_i_drive: got gnt=%b en=%b want 1 0", bus.i_gnt, bus.ram_en);
    end
    // out-of-window store aliasing word 0x41 must not touch the RAM
    @(negedge clk);
    drive_idle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_be    = 4'b1111;
    bus.d_addr  = 32'h0000_1104;
    bus.d_wdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({bus.i_rvalid, bus.i_err, bus.i_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL oow_i_rsp: got rv=%b err=%b data=%h want 1 1 0", bus.i_rvalid, bus.i_err, bus.i_rdata);
    end
    checks++;
    if ({bus.d_gnt, bus.ram_en, bus.ram_we} !== 6'b100000) begin
      errors++; $display("FAIL oow_store_drive: got gnt=%b en=%b we=%b want 1 0 0000", bus.d_gnt, bus.ram_en, bus.ram_we);
    end
    @(negedge clk);
    drive_idle();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_0104;
    #1;
    checks++;
    if ({bus.d_rvalid, bus.d_err} !== 2'b11) begin
      errors++; $display("FAIL oow_store_rsp: got rv=%b err=%b want 1 1", bus.d_rvalid, bus.d_err);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, 32'h1122_AB44}) begin
      errors++; $display("FAIL oow_no_write: got rv=%b err=%b data=%h want 1 0 1122ab44", bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
  endtask

  task automatic test_contention();
    logic [9:0]  pat;
    logic [1:0]  exp_rv;
    logic [31:0] exp_data;
    logic [31:0] got_data;
    pat = 10'b10_0001_0000;  // bit k set: fetch wins cycle k
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h4;
      end else if (k == 10) begin
        drive_idle();
      end
      #1;
      if (k < 10) begin
        checks++;
        if ({bus.i_gnt, bus.d_gnt} !== (pat[k] ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL contention_gnt[%0d]: got i/d=%b want %b", k,
                             {bus.i_gnt, bus.d_gnt}, (pat[k] ? 2'b10 : 2'b01));
        end
      end
      if (k > 0) begin
        exp_rv   = pat[k-1] ? 2'b10 : 2'b01;
        exp_data = pat[k-1] ? 32'hCAFE_0000 : 32'hCAFE_0001;
        got_data = pat[k-1] ? bus.i_rdata : bus.d_rdata;
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== exp_rv || got_data !== exp_data) begin
          errors++; $display("FAIL contention_rsp[%0d]: got rv=%b data=%h want rv=%b data=%h", k - 1,
                             {bus.i_rvalid, bus.d_rvalid}, got_data, exp_rv, exp_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h4;
    #1;
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      errors++; $display("FAIL midrst_pre_gnt: got %b want 1", bus.d_gnt);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.d_rvalid, bus.d_rdata, bus.i_gnt, bus.d_gnt, bus.ram_en, bus.i_rvalid} !== 37'h0) begin
      errors++; $display("FAIL midrst_outputs: got drv=%b ddata=%h gnt=%b%b en=%b irv=%b want 0",
                         bus.d_rvalid, bus.d_rdata, bus.i_gnt, bus.d_gnt, bus.ram_en, bus.i_rvalid);
    end
    // both held after release: four data wins then fetch proves the streak restarted
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      if (k == 0) begin
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin
          errors++; $display("FAIL midrst_no_rsp: got rv=%b want 00", {bus.i_rvalid, bus.d_rvalid});
        end
      end
      checks++;
      if ({bus.i_gnt, bus.d_gnt} !== ((k == 4) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL midrst_streak[%0d]: got i/d=%b want %b", k,
                           {bus.i_gnt, bus.d_gnt}, ((k == 4) ? 2'b10 : 2'b01));
      end
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0;
    #1;
    checks++;
    if ({bus.i_gnt, bus.ram_en, bus.ram_addr} !== {2'b11, 10'h0}) begin
      errors++; $display("FAIL midrst_fetch_gnt: got gnt=%b en=%b addr=%h want 1 1 0", bus.i_gnt, bus.ram_en, bus.ram_addr);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({bus.i_rvalid, bus.i_err, bus.i_rdata} !== {2'b10, 32'hCAFE_0000}) begin
      errors++; $display("FAIL midrst_fetch_rsp: got rv=%b err=%b data=%h want 1 0 cafe0000", bus.i_rvalid, bus.i_err, bus.i_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_word;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin
        bus.i_req  = 1'b1;
        bus.i_addr = 32'(4 * k);
      end else begin
        drive_idle();
      end
      #1;
      if (k < 3) begin
        checks++;
        if ({bus.i_gnt, bus.ram_en, bus.ram_addr} !== {2'b11, 10'(k)}) begin
          errors++; $display("FAIL b2b_gnt[%0d]: got gnt=%b en=%b addr=%0d want 1 1 %0d", k,
                             bus.i_gnt, bus.ram_en, bus.ram_addr, k);
        end
      end
      if (k > 0) begin
        exp_word = (k == 1) ? 32'hCAFE_0000 : (k == 2) ? 32'hCAFE_0001 : 32'h0050_0093;
        checks++;
        if ({bus.i_rvalid, bus.i_rdata} !== {1'b1, exp_word}) begin
          errors++; $display("FAIL b2b_rsp[%0d]: got rv=%b data=%h want 1 %h", k - 1,
                             bus.i_rvalid, bus.i_rdata, exp_word);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.ram_en, bus.i_rvalid, bus.d_rvalid, bus.i_gnt, bus.d_gnt} !== 5'b00000) begin
      errors++; $display("FAIL idle: got en/irv/drv/gnt=%b want 00000",
                         {bus.ram_en, bus.i_rvalid, bus.d_rvalid, bus.i_gnt, bus.d_gnt});
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_byte_store_load();
    test_out_of_window();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
